// File: rtl/ram_bridge_pkg.sv
// Shared bus widths, bridge state encodings and default configuration for ram_bridge.
package ram_bridge_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_REQ  = 2'd1,
    RB_RESP = 2'd2,
    RB_DONE = 2'd3
  } rb_state_t;

  localparam int                  TIMEOUT_CYCLES_DEF = 255;
  localparam logic [DATA_BUS-1:0] ERR_READ_DATA_DEF  = 32'hDEAD_BEEF;

  // Access captured from the core and held on the bus until granted
  typedef struct packed {
    logic [MEM_SEL_BUS-1:0] we;
    logic [ADDR_BUS-1:0]    addr;
    logic [DATA_BUS-1:0]    wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bridge_timeout_counter.sv
// Counts cycles spent waiting on the bus; expired pulses on the last allowed cycle.
// Latency: expired is combinational from the count. No backpressure.
// 8-bit count; clear takes priority over enable.
module bridge_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt is 0 on the first waiting cycle, so TIMEOUT_CYCLES-1 marks the last one
  assign expired = en && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_bridge.sv
// Bridges the core's single-cycle RAM port onto a req/gnt/rvalid bus, stalling the core per access.
// Latency: write 3 cycles minimum, read 4 cycles minimum (IDLE, REQ, RESP, DONE).
// Backpressure: core_stall holds the pipeline until done; RAM_BRIDGE_TIMEOUT_EN enables bus timeout abort.
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int                  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_BUS-1:0] ERR_READ_DATA  = ERR_READ_DATA_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_ram_en,
  input  logic [MEM_SEL_BUS-1:0] core_ram_write_en,
  input  logic [ADDR_BUS-1:0]    core_ram_addr,
  input  logic [DATA_BUS-1:0]    core_ram_write_data,
  output logic [DATA_BUS-1:0]    core_ram_read_data,
  input  logic                   ext_stall,
  output logic                   core_stall,
  output logic                   bus_req,
  output logic [MEM_SEL_BUS-1:0] bus_we,
  output logic [ADDR_BUS-1:0]    bus_addr,
  output logic [DATA_BUS-1:0]    bus_wdata,
  input  logic                   bus_gnt,
  input  logic                   bus_rvalid,
  input  logic [DATA_BUS-1:0]    bus_rdata,
  output logic                   bus_error,
  output logic [ADDR_BUS-1:0]    bus_error_addr
);

  rb_state_t           state, state_nxt;
  bus_cmd_t            cmd_q;
  logic [DATA_BUS-1:0] hold_q;
  logic                is_write;
  logic                tmo_abort;

  assign is_write = |cmd_q.we;

  always_comb begin
    state_nxt  = state;
    core_stall = 1'b1;
    case (state)
      RB_IDLE: begin
        core_stall = core_ram_en | ext_stall;
        if (core_ram_en) state_nxt = RB_REQ;
      end
      RB_REQ: begin
        if (bus_gnt)        state_nxt = is_write ? RB_DONE : RB_RESP;
        else if (tmo_abort) state_nxt = RB_DONE;
      end
      RB_RESP: begin
        if (bus_rvalid || tmo_abort) state_nxt = RB_DONE;
      end
      RB_DONE: begin
        core_stall = ext_stall;
        if (!ext_stall) state_nxt = RB_IDLE;
      end
      default: state_nxt = RB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RB_IDLE;
      cmd_q  <= '0;
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == RB_IDLE && core_ram_en) begin
        cmd_q <= '{we: core_ram_write_en, addr: core_ram_addr, wdata: core_ram_write_data};
      end
      // A response coinciding with the grant is not accepted: only RESP latches data
      if (state == RB_RESP && bus_rvalid) begin
        hold_q <= bus_rdata;
      end else if (tmo_abort && !is_write) begin
        hold_q <= ERR_READ_DATA;
      end
    end
  end

  assign core_ram_read_data = hold_q;
  assign bus_req            = (state == RB_REQ);
  assign bus_we             = cmd_q.we;
  assign bus_addr           = cmd_q.addr;
  assign bus_wdata          = cmd_q.wdata;

`ifdef RAM_BRIDGE_TIMEOUT_EN
  logic                tmo_expired;
  logic                err_q;
  logic [ADDR_BUS-1:0] err_addr_q;

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_nxt != state),
    .en     (state == RB_REQ || state == RB_RESP),
    .expired(tmo_expired)
  );

  // A grant or response in the expiring cycle still completes the access normally
  assign tmo_abort = tmo_expired
                     && !(state == RB_REQ  && bus_gnt)
                     && !(state == RB_RESP && bus_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (tmo_abort && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= cmd_q.addr;
    end
  end

  assign bus_error      = err_q;
  assign bus_error_addr = err_addr_q;
`else
  logic unused_cfg;

  assign unused_cfg     = ^{8'(TIMEOUT_CYCLES), ERR_READ_DATA};
  assign tmo_abort      = 1'b0;
  assign bus_error      = 1'b0;
  assign bus_error_addr = '0;
`endif

endmodule

// File: tb/tb_ram_bridge.sv
// Directed vector bench for ram_bridge: per-cycle table plus reset and timeout sequences.
module tb_ram_bridge;
  import ram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_ram_en;
  logic [3:0]  core_ram_write_en;
  logic [31:0] core_ram_addr;
  logic [31:0] core_ram_write_data;
  logic [31:0] core_ram_read_data;
  logic        ext_stall;
  logic        core_stall;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_error;
  logic [31:0] bus_error_addr;

  always #5 clk = ~clk;

  ram_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_READ_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .core_ram_en        (core_ram_en),
    .core_ram_write_en  (core_ram_write_en),
    .core_ram_addr      (core_ram_addr),
    .core_ram_write_data(core_ram_write_data),
    .core_ram_read_data (core_ram_read_data),
    .ext_stall          (ext_stall),
    .core_stall         (core_stall),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_gnt            (bus_gnt),
    .bus_rvalid         (bus_rvalid),
    .bus_rdata          (bus_rdata),
    .bus_error          (bus_error),
    .bus_error_addr     (bus_error_addr)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ext;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_stall;
    logic        exp_req;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vq[$];
  int   pass_cnt   = 0;
  int   total_cnt  = 0;
  int   wr_accepts = 0;

  always @(negedge clk) begin
    if (!rst && bus_req && bus_gnt && (|bus_we)) wr_accepts++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    core_ram_en         = en;
    core_ram_write_en   = we;
    core_ram_addr       = addr;
    core_ram_write_data = wdata;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    ext_stall  = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;

    // write 0x100, immediate grant
    vq.push_back('{1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0});
    vq.push_back('{1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    // read 0x200: grant on 2nd REQ cycle, rvalid 3 cycles later -> 7 cycles total
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D});
    // stray rvalid in IDLE is ignored
    vq.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D});
    // read 0x204: rvalid alongside grant is dropped, later response taken
    vq.push_back('{1'b1, 4'h0, 32'h204, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 4'h0, 32'h204, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 4'h0, 32'h204, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'hCAFE_F00D});
    vq.push_back('{1'b1, 4'h0, 32'h204, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h3333_3333});
    // store 0x104 held in DONE by ext_stall for 3 cycles
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_3333});
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b1, 4'h3, 32'h104, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3333_3333});
    // ext_stall alone in IDLE
    vq.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333});
    vq.push_back('{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3333_3333});

    // reset state
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_req",      32'(bus_req),    32'h0);
    chk("rst_we",       32'(bus_we),     32'h0);
    chk("rst_addr",     bus_addr,        32'h0);
    chk("rst_wdata",    bus_wdata,       32'h0);
    chk("rst_rdata",    core_ram_read_data, 32'h0);
    chk("rst_error",    32'(bus_error),  32'h0);
    chk("rst_err_addr", bus_error_addr,  32'h0);
    chk("rst_stall",    32'(core_stall), 32'h0);
    ext_stall = 1'b1;
    #1;
    chk("rst_stall_ext", 32'(core_stall), 32'h1);
    ext_stall = 1'b0;

    foreach (vq[i]) begin
      step();
      drive(vq[i].en, vq[i].we, vq[i].addr, vq[i].wdata);
      ext_stall  = vq[i].ext;
      bus_gnt    = vq[i].gnt;
      bus_rvalid = vq[i].rvalid;
      bus_rdata  = vq[i].rdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(vq[i].exp_stall));
      chk($sformatf("v%0d_req", i),   32'(bus_req),    32'(vq[i].exp_req));
      chk($sformatf("v%0d_rdata", i), core_ram_read_data, vq[i].exp_rd);
      if (vq[i].exp_req) begin
        chk($sformatf("v%0d_bus_we", i),    32'(bus_we), 32'(vq[i].we));
        chk($sformatf("v%0d_bus_addr", i),  bus_addr,    vq[i].addr);
        chk($sformatf("v%0d_bus_wdata", i), bus_wdata,   vq[i].wdata);
      end
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    chk("table_writes", 32'(wr_accepts), 32'd2);

    // reset while waiting in RESP discards the late response
    step(); drive(1'b1, 4'h0, 32'h400, 32'h0);
    #1; chk("rr_idle_stall", 32'(core_stall), 32'h1);
    step(); bus_gnt = 1'b1;
    #1; chk("rr_req", 32'(bus_req), 32'h1);
    step(); bus_gnt = 1'b0;
    #1; chk("rr_resp_stall", 32'(core_stall), 32'h1);
    rst = 1'b1;
    step(); rst = 1'b0; drive(1'b0, 4'h0, 32'h0, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'h55AA_55AA;
    #1;
    chk("rr_req_drop", 32'(bus_req),    32'h0);
    chk("rr_stall",    32'(core_stall), 32'h0);
    chk("rr_rdata0",   core_ram_read_data, 32'h0);
    step(); bus_rvalid = 1'b0;
    #1;
    chk("rr_rdata1", core_ram_read_data, 32'h0);
    chk("rr_stall1", 32'(core_stall),    32'h0);

    // load from 0x300 with no grant
    step(); drive(1'b1, 4'h0, 32'h300, 32'h0);
    #1; chk("to_idle_stall", 32'(core_stall), 32'h1);
`ifdef RAM_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("to_req%0d", i), 32'(bus_req), 32'h1);
    end
    step();
    chk("to_done_stall", 32'(core_stall), 32'h0);
    chk("to_done_req",   32'(bus_req),    32'h0);
    chk("to_rdata",      core_ram_read_data, 32'hDEAD_BEEF);
    chk("to_error",      32'(bus_error),  32'h1);
    chk("to_err_addr",   bus_error_addr,  32'h300);
    step(); drive(1'b0, 4'h0, 32'h0, 32'h0);
    #1; chk("to_idle", 32'(core_stall), 32'h0);
    step(); drive(1'b1, 4'hF, 32'h500, 32'h0000_0001);
    step(); bus_gnt = 1'b1;
    #1; chk("to_wr_req", 32'(bus_req), 32'h1);
    step(); bus_gnt = 1'b0;
    #1;
    chk("to_wr_done",  32'(core_stall),    32'h0);
    chk("to_wr_rdata", core_ram_read_data, 32'hDEAD_BEEF);
    step(); drive(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("to_err_sticky",   32'(bus_error), 32'h1);
    chk("to_err_addr_kept", bus_error_addr, 32'h300);
    chk("to_writes", 32'(wr_accepts), 32'd3);
`else
    for (int i = 0; i < 50; i++) begin
      step();
      chk($sformatf("hang_stall%0d", i), 32'(core_stall), 32'h1);
      chk($sformatf("hang_error%0d", i), 32'(bus_error),  32'h0);
    end
    step(); bus_gnt = 1'b1;
    #1; chk("hang_req", 32'(bus_req), 32'h1);
    step(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step(); bus_rvalid = 1'b0;
    #1;
    chk("hang_done_stall", 32'(core_stall),    32'h0);
    chk("hang_rdata",      core_ram_read_data, 32'h0BAD_F00D);
    chk("hang_err_addr",   bus_error_addr,     32'h0);
    step(); drive(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("hang_writes", 32'(wr_accepts), 32'd2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
